line_fetch_scheduler: RTL and testbench

Per-scanline fetch sequencer for the sprite layers. It sits between the VGA timing generator and the per-layer colour comparators. During each horizontal blank it works out which layers (player, obstacle, score) cross the next scanline and reads each one's 16-pixel row bitmap from a shared single-port sprite ROM. The fetched rows are held in shadow registers and handed to the comparators at the start of active video.

---
 rtl/line_fetch_scheduler.sv | 231 +++++++++++++++++++++++
 tb/tb_line_fetch_scheduler.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/line_fetch_scheduler.sv
// line_fetch_scheduler: per-scanline sprite row fetch into shadow registers.
// Score layer is sequenced only when LINE_FETCH_SCORE_EN is defined.
module line_fetch_scheduler #(
  parameter int HEIGHT = 16,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_line_start,
  input  logic              i_line_commit,
  input  logic [8:0]        i_vpos,
  input  logic [8:0]        i_player_y,
  input  logic [8:0]        i_obstacle_y,
  input  logic [8:0]        i_score_y,
  output logic              o_rom_en,
  output logic [ADDR_W-1:0] o_rom_addr,
  input  logic [DATA_W-1:0] i_rom_data,
  output logic [DATA_W-1:0] o_row_player,
  output logic [DATA_W-1:0] o_row_obstacle,
  output logic [DATA_W-1:0] o_row_score,
  output logic              o_line_valid,
  output logic              o_busy,
  output logic              o_overrun,
  output logic              o_underrun
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    P_ISSUE = 3'd1,
    P_CAP   = 3'd2,
    O_ISSUE = 3'd3,
    O_CAP   = 3'd4,
`ifdef LINE_FETCH_SCORE_EN
    S_ISSUE = 3'd5,
    S_CAP   = 3'd6,
`endif
    DONE    = 3'd7
  } state_t;

`ifdef LINE_FETCH_SCORE_EN
  localparam state_t AFTER_O = S_ISSUE;
`else
  localparam state_t AFTER_O = DONE;
`endif

  state_t            state_q, state_d;
  logic [8:0]        vpos_q, vpos_d;
  logic [DATA_W-1:0] sh_p_q, sh_p_d;
  logic [DATA_W-1:0] sh_o_q, sh_o_d;
  logic [DATA_W-1:0] row_p_q, row_p_d;
  logic [DATA_W-1:0] row_o_q, row_o_d;
  logic              valid_q, valid_d;
  logic              ovr_q, ovr_d;
  logic              und_q, und_d;
  logic              busy;
  logic [8:0]        row_p, row_o;
  logic              act_p, act_o;
  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;

  // Unsigned 9-bit difference: layers above vpos wrap large and read inactive
  assign row_p = vpos_q - i_player_y;
  assign row_o = vpos_q - i_obstacle_y;
  assign act_p = row_p < 9'(HEIGHT);
  assign act_o = row_o < 9'(HEIGHT);

`ifdef LINE_FETCH_SCORE_EN
  logic [DATA_W-1:0] sh_s_q, sh_s_d;
  logic [DATA_W-1:0] row_s_q, row_s_d;
  logic [8:0]        row_s;
  logic              act_s;

  assign row_s = vpos_q - i_score_y;
  assign act_s = row_s < 9'(HEIGHT);
`else
  logic unused_score_y;

  assign unused_score_y = ^i_score_y;
`endif

  assign busy = (state_q != IDLE) && (state_q != DONE);

  always_comb begin
    state_d  = state_q;
    vpos_d   = vpos_q;
    sh_p_d   = sh_p_q;
    sh_o_d   = sh_o_q;
    row_p_d  = row_p_q;
    row_o_d  = row_o_q;
    valid_d  = valid_q;
    ovr_d    = ovr_q;
    und_d    = und_q;
    rom_en   = 1'b0;
    rom_addr = '0;
`ifdef LINE_FETCH_SCORE_EN
    sh_s_d   = sh_s_q;
    row_s_d  = row_s_q;
`endif

    unique case (state_q)
      P_ISSUE: begin
        if (act_p) begin
          rom_en   = 1'b1;
          rom_addr = ADDR_W'({2'd0, row_p[3:0]});
          state_d  = P_CAP;
        end else begin
          sh_p_d  = '0;
          state_d = O_ISSUE;
        end
      end
      P_CAP: begin
        sh_p_d  = i_rom_data;
        state_d = O_ISSUE;
      end
      O_ISSUE: begin
        if (act_o) begin
          rom_en   = 1'b1;
          rom_addr = ADDR_W'({2'd1, row_o[3:0]});
          state_d  = O_CAP;
        end else begin
          sh_o_d  = '0;
          state_d = AFTER_O;
        end
      end
      O_CAP: begin
        sh_o_d  = i_rom_data;
        state_d = AFTER_O;
      end
`ifdef LINE_FETCH_SCORE_EN
      S_ISSUE: begin
        if (act_s) begin
          rom_en   = 1'b1;
          rom_addr = ADDR_W'({2'd2, row_s[3:0]});
          state_d  = S_CAP;
        end else begin
          sh_s_d  = '0;
          state_d = DONE;
        end
      end
      S_CAP: begin
        sh_s_d  = i_rom_data;
        state_d = DONE;
      end
`endif
      default: ;
    endcase

    // Commit sees the current state; a coincident start then overrides
    if (i_line_commit) begin
      if (state_q == DONE) begin
        row_p_d = sh_p_q;
        row_o_d = sh_o_q;
        valid_d = 1'b1;
        state_d = IDLE;
`ifdef LINE_FETCH_SCORE_EN
        row_s_d = sh_s_q;
`endif
      end else begin
        row_p_d = '0;
        row_o_d = '0;
        valid_d = 1'b0;
        und_d   = 1'b1;
`ifdef LINE_FETCH_SCORE_EN
        row_s_d = '0;
`endif
      end
    end

    if (i_line_start) begin
      vpos_d  = i_vpos;
      state_d = P_ISSUE;
      sh_p_d  = '0;
      sh_o_d  = '0;
`ifdef LINE_FETCH_SCORE_EN
      sh_s_d  = '0;
`endif
      if (busy) ovr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      vpos_q  <= '0;
      sh_p_q  <= '0;
      sh_o_q  <= '0;
      row_p_q <= '0;
      row_o_q <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      und_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vpos_q  <= vpos_d;
      sh_p_q  <= sh_p_d;
      sh_o_q  <= sh_o_d;
      row_p_q <= row_p_d;
      row_o_q <= row_o_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      und_q   <= und_d;
    end
  end

`ifdef LINE_FETCH_SCORE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_s_q  <= '0;
      row_s_q <= '0;
    end else begin
      sh_s_q  <= sh_s_d;
      row_s_q <= row_s_d;
    end
  end

  assign o_row_score = row_s_q;
`else
  assign o_row_score = '0;
`endif

  assign o_rom_en       = rom_en;
  assign o_rom_addr     = rom_addr;
  assign o_row_player   = row_p_q;
  assign o_row_obstacle = row_o_q;
  assign o_line_valid   = valid_q;
  assign o_busy         = busy;
  assign o_overrun      = ovr_q;
  assign o_underrun     = und_q;

endmodule

// File: tb/tb_line_fetch_scheduler.sv
// Directed bench for line_fetch_scheduler.
// Expected timing follows LINE_FETCH_SCORE_EN when it is defined.
module tb_line_fetch_scheduler;

`ifdef LINE_FETCH_SCORE_EN
  localparam int ALL_DONE  = 7;
  localparam int NONE_DONE = 4;
  localparam int P_DONE    = 5;
  localparam logic [15:0] S_ALL = 16'hA587;
`else
  localparam int ALL_DONE  = 5;
  localparam int NONE_DONE = 3;
  localparam int P_DONE    = 4;
  localparam logic [15:0] S_ALL = 16'h0000;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        line_start;
  logic        line_commit;
  logic [8:0]  vpos, py, oy, sy;
  logic        rom_en;
  logic [5:0]  rom_addr;
  logic [15:0] rom_data;
  logic [15:0] row_p, row_o, row_s;
  logic        line_valid, busy, overrun, underrun;

  int checks = 0;
  int errors = 0;

  line_fetch_scheduler #(
    .HEIGHT(16),
    .ADDR_W(6),
    .DATA_W(16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .i_line_start  (line_start),
    .i_line_commit (line_commit),
    .i_vpos        (vpos),
    .i_player_y    (py),
    .i_obstacle_y  (oy),
    .i_score_y     (sy),
    .o_rom_en      (rom_en),
    .o_rom_addr    (rom_addr),
    .i_rom_data    (rom_data),
    .o_row_player  (row_p),
    .o_row_obstacle(row_o),
    .o_row_score   (row_s),
    .o_line_valid  (line_valid),
    .o_busy        (busy),
    .o_overrun     (overrun),
    .o_underrun    (underrun)
  );

  always #5 clk = ~clk;

  // ROM: latency 1, filler when not strobed so stray captures show
  always @(posedge clk) begin
    if (rom_en) rom_data <= 16'hA5A0 ^ {10'd0, rom_addr};
    else        rom_data <= 16'hDEAD;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_line(input logic [8:0] v, input logic [8:0] p,
                            input logic [8:0] o, input logic [8:0] s);
    vpos = v; py = p; oy = o; sy = s;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
  endtask

  task automatic commit();
    line_commit = 1'b1;
    tick();
    line_commit = 1'b0;
  endtask

  task automatic strobe(input string tag, input logic en,
                        input logic [5:0] addr);
    check({tag, "_en"}, rom_en, en);
    if (en) check({tag, "_addr"}, rom_addr, addr);
  endtask

  task automatic finish_seq(input string tag, input int now,
                            input int done);
    for (int c = now + 1; c < done; c++) begin
      tick();
      check({tag, "_busy"}, busy, 1);
    end
    tick();
    check({tag, "_done"}, busy, 0);
  endtask

  task automatic rows(input string tag, input logic [15:0] p,
                      input logic [15:0] o, input logic [15:0] s,
                      input logic v);
    check({tag, "_rp"}, row_p, p);
    check({tag, "_ro"}, row_o, o);
    check({tag, "_rs"}, row_s, s);
    check({tag, "_valid"}, line_valid, v);
  endtask

  initial begin
    reset = 1'b1;
    line_start = 1'b0;
    line_commit = 1'b0;
    vpos = '0; py = '0; oy = '0; sy = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // reset state
    rows("rst", 0, 0, 0, 0);
    check("rst_en", rom_en, 0);
    check("rst_addr", rom_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_ovr", overrun, 0);
    check("rst_und", underrun, 0);

    // player only: row 5
    start_line(9'd100, 9'd95, 9'd200, 9'd0);
    check("p1_busy", busy, 1);
    strobe("p1_c1", 1, 6'h05);
    tick();
    strobe("p1_c2", 0, 0);
    tick();
    strobe("p1_c3", 0, 0);
    finish_seq("p1", 3, P_DONE);
    commit();
    rows("p1_cm", 16'hA5A5, 0, 0, 1);
    check("p1_und", underrun, 0);

    // all active: row 7 for every layer
    start_line(9'd10, 9'd3, 9'd3, 9'd3);
    strobe("all_c1", 1, 6'h07);
    tick();
    strobe("all_c2", 0, 0);
    tick();
    strobe("all_c3", 1, 6'h17);
    tick();
    strobe("all_c4", 0, 0);
`ifdef LINE_FETCH_SCORE_EN
    tick();
    strobe("all_c5", 1, 6'h27);
    tick();
    strobe("all_c6", 0, 0);
    finish_seq("all", 6, ALL_DONE);
`else
    finish_seq("all", 4, ALL_DONE);
`endif
    commit();
    rows("all_cm", 16'hA5A7, 16'hA5B7, S_ALL, 1);
    check("all_und", underrun, 0);

    // early commit at cycle 3
    start_line(9'd10, 9'd3, 9'd3, 9'd3);
    tick();
    tick();
    strobe("ec_c3", 1, 6'h17);
    commit();
    rows("ec", 0, 0, 0, 0);
    check("ec_und", underrun, 1);
    check("ec_busy", busy, 1);
`ifdef LINE_FETCH_SCORE_EN
    tick();
    strobe("ec_c5", 1, 6'h27);
    finish_seq("ec", 5, ALL_DONE);
`else
    finish_seq("ec", 4, ALL_DONE);
`endif
    commit();
    rows("ec_cm", 16'hA5A7, 16'hA5B7, S_ALL, 1);
    check("ec_ovr", overrun, 0);

    // overrun: restart at cycle 4 with a player-only line
    start_line(9'd10, 9'd3, 9'd3, 9'd3);
    tick();
    tick();
    tick();
    start_line(9'd100, 9'd95, 9'd200, 9'd0);
    check("ov_ovr", overrun, 1);
    check("ov_busy", busy, 1);
    strobe("ov_c1", 1, 6'h05);
    finish_seq("ov", 1, P_DONE);

    // commit and start together in DONE: wrap-around row 14
    line_commit = 1'b1;
    start_line(9'd2, 9'd500, 9'd200, 9'd200);
    line_commit = 1'b0;
    rows("ov_cm", 16'hA5A5, 0, 0, 1);
    check("sim_busy", busy, 1);
    strobe("wrap_c1", 1, 6'h0E);
    finish_seq("wrap", 1, P_DONE);
    commit();
    rows("wrap_cm", 16'hA5AE, 0, 0, 1);

    // row 511 is inactive
    start_line(9'd20, 9'd21, 9'd200, 9'd200);
    check("none_busy", busy, 1);
    strobe("none_c1", 0, 0);
    tick();
    strobe("none_c2", 0, 0);
    finish_seq("none", 2, NONE_DONE);
    commit();
    rows("none_cm", 0, 0, 0, 1);

    // reset asserted in O_CAP
    start_line(9'd10, 9'd3, 9'd3, 9'd3);
    tick();
    tick();
    tick();
    reset = 1'b1;
    #1;
    rows("mr", 0, 0, 0, 0);
    check("mr_en", rom_en, 0);
    check("mr_addr", rom_addr, 0);
    check("mr_busy", busy, 0);
    check("mr_ovr", overrun, 0);
    check("mr_und", underrun, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick();
    check("mr_idle", busy, 0);
    check("mr_en2", rom_en, 0);

    start_line(9'd100, 9'd95, 9'd200, 9'd0);
    strobe("pr_c1", 1, 6'h05);
    finish_seq("pr", 1, P_DONE);
    commit();
    rows("pr_cm", 16'hA5A5, 0, 0, 1);
    check("pr_ovr", overrun, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
